// File: rtl/game_scene_ctrl.sv
// ---------------------------------------------------------------------------
// game_scene_ctrl
//
// Top-level game sequencer for the shooter. Owns the scene register
// (TITLE/PLAY/WIN/LOSE), the player life count, a 4-digit BCD score and the
// invincibility/blink timer that drives the player sprite visibility.
//
// Ports:
//   clk_25m     in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per frame (time base for all counters)
//   btn_start   in   debounced start button, level
//   hit_player  in   pulse: player collided with a bullet or enemy
//   kill_enemy  in   pulse: an enemy was destroyed
//   boss_dead   in   pulse: boss destroyed
//   scene       out  00 TITLE, 01 PLAY, 10 WIN, 11 LOSE (also the FSM state)
//   life        out  remaining lives, 3..0
//   score0..3   out  BCD score digits, score0 = ones, score3 = thousands
//   reimuE      out  player sprite visible
//   game_rst    out  one-cycle pulse on game start
//   play_en     out  high while scene == PLAY
//
// Event protocol: hit_player, kill_enemy, boss_dead and frame_tick are
// single-cycle pulses sampled on every rising clock edge; there is no
// back-pressure. btn_start is a level; only its rising edge acts. Every
// output is registered and reflects an event one cycle after its pulse.
// ---------------------------------------------------------------------------
module game_scene_ctrl #(
  parameter int INV_FRAMES   = 120,
  parameter int BLINK_FRAMES = 8,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       hit_player,
  input  logic       kill_enemy,
  input  logic       boss_dead,
  output logic [1:0] scene,
  output logic [1:0] life,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic       reimuE,
  output logic       game_rst,
  output logic       play_en
);

  typedef enum logic [1:0] {
    SC_TITLE = 2'b00,
    SC_PLAY  = 2'b01,
    SC_WIN   = 2'b10,
    SC_LOSE  = 2'b11
  } scene_e;

  // Bit of inv_cnt whose value selects the on/off blink phase.
  localparam int BLINK_BIT = $clog2(BLINK_FRAMES);

  localparam logic [7:0] INV_LOAD  = 8'(INV_FRAMES);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);

  scene_e      state_q, state_d;
  logic        btn_q;
  logic [1:0]  life_q, life_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  inv_q, inv_d;
  logic [7:0]  hold_q, hold_d;
  logic        reimu_q, reimu_d;
  logic        game_rst_q, game_rst_d;
  logic        play_en_q, play_en_d;

  logic        start_re;
  logic        hit_ok;

  // Increment a packed 4-digit BCD value starting at digit 'pos' with ripple
  // carry. Bit 16 of the result is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v, input int pos);
    logic [16:0] r;
    logic        carry;
    r     = {1'b0, v};
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= pos && carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    r[16] = carry;
    return r;
  endfunction

  // Score adder: +1 on kill, then +100 on boss; any carry out of the
  // thousands digit means the true sum exceeded 9999, so saturate.
  logic [16:0] kill_sum;
  logic [16:0] boss_sum;
  logic [15:0] kill_val;
  logic        score_ovf;
  logic [15:0] score_add;

  assign kill_sum  = bcd_inc(score_q, 0);
  assign kill_val  = kill_enemy ? kill_sum[15:0] : score_q;
  assign boss_sum  = bcd_inc(kill_val, 2);
  assign score_ovf = (kill_enemy & kill_sum[16]) | (boss_dead & boss_sum[16]);
  assign score_add = score_ovf ? 16'h9999 : (boss_dead ? boss_sum[15:0] : kill_val);

  assign start_re = btn_start & ~btn_q;
  // A boss kill in the same cycle overrides the hit.
  assign hit_ok   = hit_player & ~boss_dead & (inv_q == 8'd0);

  // ---------------- state register ----------------
  // btn_q resets high so a button held through reset is not a start edge.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SC_TITLE;
      btn_q      <= 1'b1;
      life_q     <= 2'd3;
      score_q    <= 16'h0000;
      inv_q      <= 8'd0;
      hold_q     <= 8'd0;
      reimu_q    <= 1'b0;
      game_rst_q <= 1'b0;
      play_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_start;
      life_q     <= life_d;
      score_q    <= score_d;
      inv_q      <= inv_d;
      hold_q     <= hold_d;
      reimu_q    <= reimu_d;
      game_rst_q <= game_rst_d;
      play_en_q  <= play_en_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SC_TITLE: if (start_re) state_d = SC_PLAY;
      SC_PLAY: begin
        if (boss_dead)                       state_d = SC_WIN;
        else if (hit_ok && life_q == 2'd1)   state_d = SC_LOSE;
      end
      SC_WIN, SC_LOSE: if (start_re && hold_q == 8'd0) state_d = SC_TITLE;
      default: state_d = SC_TITLE;
    endcase
  end

  // Game datapath: lives, score, invincibility and hold counters.
  always_comb begin
    life_d  = life_q;
    score_d = score_q;
    inv_d   = inv_q;
    hold_d  = hold_q;
    unique case (state_q)
      SC_TITLE: begin
        if (start_re) begin
          life_d  = 2'd3;
          score_d = 16'h0000;
          inv_d   = 8'd0;
        end
      end
      SC_PLAY: begin
        score_d = score_add;
        if (hit_ok) begin
          if (life_q == 2'd1) begin
            life_d = 2'd0;
          end else begin
            life_d = life_q - 2'd1;
            inv_d  = INV_LOAD;   // reload wins over a coincident frame_tick
          end
        end else if (frame_tick && inv_q != 8'd0) begin
          inv_d = inv_q - 8'd1;
        end
        if (state_d != SC_PLAY) hold_d = HOLD_LOAD;
      end
      SC_WIN, SC_LOSE: begin
        if (frame_tick && hold_q != 8'd0) hold_d = hold_q - 8'd1;
      end
      default: ;
    endcase
  end

  // ---------------- output logic ----------------
  // Outputs are computed from next-state values and registered, so they
  // change on the same edge that samples the triggering event.
  always_comb begin
    play_en_d  = (state_d == SC_PLAY);
    game_rst_d = (state_q == SC_TITLE) && start_re;
    // Sprite blinks while invincible; the inverted phase bit keeps it off
    // for the first aligned phase after a hit.
    reimu_d    = (state_d == SC_PLAY) && ((inv_d == 8'd0) || !inv_d[BLINK_BIT]);
  end

  assign scene    = state_q;
  assign life     = life_q;
  assign score0   = score_q[3:0];
  assign score1   = score_q[7:4];
  assign score2   = score_q[11:8];
  assign score3   = score_q[15:12];
  assign reimuE   = reimu_q;
  assign game_rst = game_rst_q;
  assign play_en  = play_en_q;

endmodule

// File: tb/tb_game_scene_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_scene_ctrl
//
// Stimulus process drives one cycle at a time, advances a behavioural game
// model and pushes the expected output vector into exp_q. A separate monitor
// pops one entry after every rising edge and compares it with the DUT.
// Directed spot checks at scenario milestones use fixed constants.
// ---------------------------------------------------------------------------
module tb_game_scene_ctrl;

  localparam int INV   = 120;
  localparam int BLINK = 8;
  localparam int HOLD  = 60;
  localparam int W     = 23;

  // ---------------- clock / reset ----------------
  logic clk_25m = 1'b0;
  logic rst_n;
  always #5 clk_25m = ~clk_25m;

  logic       frame_tick, btn_start, hit_player, kill_enemy, boss_dead;
  logic [1:0] scene, life;
  logic [3:0] score0, score1, score2, score3;
  logic       reimuE, game_rst, play_en;

  game_scene_ctrl #(
    .INV_FRAMES  (INV),
    .BLINK_FRAMES(BLINK),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .btn_start (btn_start),
    .hit_player(hit_player),
    .kill_enemy(kill_enemy),
    .boss_dead (boss_dead),
    .scene     (scene),
    .life      (life),
    .score0    (score0),
    .score1    (score1),
    .score2    (score2),
    .score3    (score3),
    .reimuE    (reimuE),
    .game_rst  (game_rst),
    .play_en   (play_en)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  int m_scene, m_life, m_score, m_inv, m_hold;
  bit m_btn, m_grst;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [W-1:0] model_vec();
    bit vis;
    vis = (m_scene == 1) && (m_inv == 0 || ((m_inv / BLINK) % 2) == 0);
    return {2'(m_scene), 2'(m_life), to_bcd(m_score), vis, m_grst, m_scene == 1};
  endfunction

  task automatic model_edge(input bit btn, input bit kill, input bit boss,
                            input bit hit, input bit tick);
    bit sr;
    if (!rst_n) begin
      m_scene = 0; m_life = 3; m_score = 0; m_inv = 0; m_hold = 0;
      m_btn = 1'b1; m_grst = 1'b0;
    end else begin
      sr     = btn && !m_btn;
      m_btn  = btn;
      m_grst = 1'b0;
      case (m_scene)
        0: if (sr) begin
          m_scene = 1; m_grst = 1'b1; m_life = 3; m_score = 0; m_inv = 0;
        end
        1: begin
          m_score = m_score + int'(kill) + 100 * int'(boss);
          if (m_score > 9999) m_score = 9999;
          if (boss) begin
            m_scene = 2; m_hold = HOLD;
          end else if (hit && m_inv == 0) begin
            if (m_life == 1) begin
              m_life = 0; m_scene = 3; m_hold = HOLD;
            end else begin
              m_life = m_life - 1; m_inv = INV;
            end
          end else if (tick && m_inv > 0) begin
            m_inv = m_inv - 1;
          end
        end
        default: begin
          if (sr && m_hold == 0) m_scene = 0;
          else if (tick && m_hold > 0) m_hold = m_hold - 1;
        end
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit btn, input bit kill, input bit boss,
                      input bit hit, input bit tick);
    btn_start  = btn;
    kill_enemy = kill;
    boss_dead  = boss;
    hit_player = hit;
    frame_tick = tick;
    model_edge(btn, kill, boss, hit, tick);
    exp_q.push_back(model_vec());
    @(posedge clk_25m);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic press_start();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Leave WIN/LOSE and start a fresh game.
  task automatic new_game();
    frames(HOLD);
    press_start();
    idle(1);
    check("back_to_title", int'(scene), 0);
    press_start();
    check("new_game_scene", int'(scene), 1);
    idle(1);
  endtask

  // Assert reset between clock edges (after the monitor has sampled) and
  // check the outputs drop immediately, without a clock.
  task automatic async_reset();
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs",
          int'({scene, life, score3, score2, score1, score0, reimuE, game_rst, play_en}),
          int'({2'd0, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0}));
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk_25m);
      #3;
      if (run) begin
        act_v = {scene, life, score3, score2, score1, score0, reimuE, game_rst, play_en};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got scene=%0d life=%0d score=%h reimuE=%0b game_rst=%0b play_en=%0b, expected scene=%0d life=%0d score=%h reimuE=%0b game_rst=%0b play_en=%0b",
                     $time, act_v[22:21], act_v[20:19], act_v[18:3], act_v[2], act_v[1], act_v[0],
                     exp_v[22:21], exp_v[20:19], exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n = 1'b0;
    btn_start = 1'b1; frame_tick = 1'b0; hit_player = 1'b0;
    kill_enemy = 1'b0; boss_dead = 1'b0;
    run = 1'b1;

    // Button held through reset release: no start.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_btn_no_start", int'(scene), 0);
    check("held_btn_no_game_rst", int'(game_rst), 0);
    idle(2);

    // Start a game.
    press_start();
    check("start_scene", int'(scene), 1);
    check("start_game_rst", int'(game_rst), 1);
    check("start_life", int'(life), 3);
    check("start_score", int'({score3, score2, score1, score0}), 'h0000);
    idle(1);
    check("game_rst_one_cycle", int'(game_rst), 0);

    // 12 kills then boss -> 0112, WIN.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("boss_score", int'({score3, score2, score1, score0}), 'h0112);
    check("boss_scene", int'(scene), 2);
    new_game();

    // Hit, second hit 5 frames later, third hit INV+1 frames after first.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hit1_life", int'(life), 2);
    check("hit1_reimu_off", int'(reimuE), 0);
    frames(5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hit2_ignored_life", int'(life), 2);
    frames(INV + 1 - 5);
    check("inv_expired_visible", int'(reimuE), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hit3_life", int'(life), 1);

    // Last life lost -> LOSE; early start ignored, late start accepted.
    frames(INV);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lose_life", int'(life), 0);
    check("lose_scene", int'(scene), 3);
    frames(10);
    press_start();
    check("early_start_ignored", int'(scene), 3);
    idle(1);
    frames(60);
    press_start();
    check("late_start_title", int'(scene), 0);
    idle(1);
    press_start();
    idle(1);

    // Hit and boss together at life 1: boss wins.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(INV);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(INV);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("hit_boss_scene", int'(scene), 2);
    check("hit_boss_life", int'(life), 1);
    new_game();

    // Kill and boss together -> +101.
    k = $urandom_range(3, 20);
    for (int i = 0; i < k; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("kill_boss_score", int'({score3, score2, score1, score0}), int'(to_bcd(k + 101)));
    new_game();

    // Saturation at 9999.
    for (int i = 0; i < 9998; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("score_9998", int'({score3, score2, score1, score0}), 'h9998);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("score_sat", int'({score3, score2, score1, score0}), 'h9999);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("score_sat_boss", int'({score3, score2, score1, score0}), 'h9999);
    new_game();

    // Randomized play.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) == 0));
    end
    async_reset();

    // Reset in the middle of PLAY.
    press_start();
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    async_reset();
    check("after_rst_scene", int'(scene), 0);
    check("after_rst_game_rst", int'(game_rst), 0);

    #5;
    run = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_scene_ctrl.md
# game_scene_ctrl

Top-level game sequencer for the shooter. It owns the scene register (title, play, win, lose), the player life count, the 4-digit BCD score and the player invincibility/blink timer. It drives the `scene`, `life`, `score0..score3` and `reimuE` inputs of the pixel renderer, and a one-cycle `game_rst` that clears all object-motion logic when a new game starts. Events come in as single-cycle pulses from the collision logic; time is counted in frames using a per-frame tick from the sync generator.

## Interface
Parameters:
- INV_FRAMES, 120, length of invincibility after a hit, in frames (1..255)
- BLINK_FRAMES, 8, frames per `reimuE` on/off phase while invincible (power of 2, ≥2)
- HOLD_FRAMES, 60, minimum frames spent in WIN/LOSE before start is accepted (1..255)

Ports:
- clk_25m  in  1  pixel clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- frame_tick  in  1  one-cycle pulse per frame
- btn_start  in  1  debounced start button, level
- hit_player  in  1  pulse: player collided with a bullet or enemy
- kill_enemy  in  1  pulse: an enemy was destroyed
- boss_dead  in  1  pulse: boss destroyed
- scene  out  2  00 TITLE, 01 PLAY, 10 WIN, 11 LOSE
- life  out  2  remaining lives, 3..0
- score0..score3  out  4 each  BCD score digits; score0 = ones, score3 = thousands
- reimuE  out  1  player sprite visible
- game_rst  out  1  one-cycle pulse on game start
- play_en  out  1  high while scene == PLAY

## Operation
- Start edge: `start_re = btn_start & ~btn_q`, where `btn_q` is registered `btn_start`. `btn_q` resets to 1, so holding the button through reset does not start a game.
- **TITLE:** on `start_re`, go to PLAY. In the same cycle, pulse `game_rst`, set life to 3, clear the score to 0000, and clear the invincibility counter `inv_cnt`.
- **PLAY:**
  - `kill_enemy`: score + 1, BCD with ripple carry.
  - `boss_dead`: score + 100 (increment score2 with carry into score3), then go to WIN.
  - Score saturates at 9999. Any add that would exceed 9999 leaves all digits at 9.
  - If `kill_enemy` and `boss_dead` arrive in the same cycle, the score gains 101 (with saturation).
  - `hit_player` when `inv_cnt == 0`:
    - life == 1: life becomes 0 and the scene goes to LOSE.
    - Otherwise: life − 1 and `inv_cnt` loads INV_FRAMES.
  - `hit_player` while `inv_cnt != 0` is ignored.
  - `boss_dead` with `hit_player` in the same cycle: boss wins. Go to WIN; life is unchanged.
  - On each `frame_tick` with `inv_cnt != 0`, decrement `inv_cnt`.
- **WIN / LOSE:**
  - `hold_cnt` loads HOLD_FRAMES on entry and decrements on each `frame_tick` down to 0.
  - `start_re` while `hold_cnt == 0`: go to TITLE. No game state is cleared here; the score stays visible until the next start.
  - `start_re` while `hold_cnt != 0` is ignored.
  - Event pulses have no effect.
- **reimuE:**
  - Low in TITLE, WIN and LOSE.
  - In PLAY, high when `inv_cnt == 0`.
  - Otherwise it equals bit log2(BLINK_FRAMES) of `inv_cnt`, inverted, so it is off for the first BLINK_FRAMES-aligned phase after a hit.
- Event inputs are ignored in TITLE.

## Timing
- All outputs are registered. Each output updates on the clock edge that samples its event, i.e. it is visible one cycle after the event pulse is high.
- `game_rst` is high for exactly one cycle, the same cycle `scene` becomes 01.
- Reset values: scene = 00, life = 3, score = 0000, reimuE = 0, game_rst = 0, play_en = 0, inv_cnt = 0, hold_cnt = 0.
- Reset asserted in the middle of a game returns to TITLE immediately (asynchronously) and produces no `game_rst` pulse.
- A `frame_tick` that coincides with a hit reload: the reload wins, and `inv_cnt` = INV_FRAMES.
- Counters are 8 bits. All BCD adds complete in a single cycle.

## Test plan
- Reset, then pulse `btn_start` → 1 cycle later: scene = 01, `game_rst` = 1 for one cycle, life = 3, score = 0000.
- PLAY, 12 `kill_enemy` pulses then `boss_dead` → score = 0112, scene = 10. Preload 9998, then two kills → score = 9999 (saturated).
- `hit_player` at life 3, second hit 5 frames later, third hit INV_FRAMES+1 frames after the first → life = 3 → 2 → 2 → 1. `reimuE` toggles every 8 frames during invincibility.
- life = 1 and `hit_player` → life = 0, scene = 11. `start_re` 10 frames later is ignored. `start_re` after 60 frames → scene = 00.
- `hit_player` and `boss_dead` in the same cycle at life 1 → scene = 10, life = 1. `kill_enemy` and `boss_dead` together → score + 101.
- `btn_start` held high across deassertion of `rst_n` → no start. Assert `rst_n` low in the middle of PLAY → all outputs return to their reset values asynchronously.
